sparse_pe_v2: RTL and testbench
===============================

Name: sparse_pe_v2

Overview:
- Next-generation weight-stationary processing element for the sparse systolic array.
- Holds ROWS x BETA N:M-compressed weights in a double buffer that is loaded over a tagged shift chain.
- Uses each weight's metadata to select its activation from an M-wide block, then runs a 2-stage pipelined multiply, reduce and accumulate.
- Forwards activations right and partial sums down, each with an explicit valid.

Parameters:
- ROWS, 2: independent dot-product rows (output channels) in this PE
- BETA, 4: compressed weights per row; also the number of activation blocks
- M, 4: sparsity block size; META_W = $clog2(M) (derived, not overridable)
- MUL_DW, 8: signed weight/activation width
- ADD_DW, 32: signed accumulator width
- TAG_W, 4: weight-chain destination tag width
- PE_ID, 0: tag value this PE captures
- SAT, 0: 1 = saturating accumulate, 0 = wrap modulo 2^ADD_DW

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- act_in  in  MUL_DW*M*BETA  BETA blocks of M activations; block b, element k at [(b*M+k)*MUL_DW +: MUL_DW]
- act_valid_in  in  1  act_in valid
- acc_in  in  ROWS*ADD_DW  partial sums from the PE above
- w_in  in  ROWS*BETA*(MUL_DW+META_W)  weight words; each slot = {meta, weight}
- w_valid_in  in  1  w_in/w_tag_in valid
- w_tag_in  in  TAG_W  destination PE of w_in
- i_wb  in  1  buffer that receives loads; compute reads buffer !i_wb
- clear  in  1  synchronous flush of pipeline valids and buffer-loaded flags
- act_out  out  MUL_DW*M*BETA  registered act_in
- act_valid_out  out  1  registered act_valid_in
- w_out  out  ROWS*BETA*(MUL_DW+META_W)  registered w_in (shift chain)
- w_valid_out  out  1  registered w_valid_in
- w_tag_out  out  TAG_W  registered w_tag_in
- acc_out  out  ROWS*ADD_DW  partial sums to the PE below
- acc_valid_out  out  1  acc_out valid
- err  out  1  sticky: compute was issued from an unloaded buffer

Behaviour:
- Reset (rst_n=0, async): all outputs, both buffers, loaded[1:0], pipeline registers and err go to 0. clear has the same effect synchronously, except that it leaves buffer contents intact and still forwards act/w that cycle.
- Forwarding:
  - act_out/act_valid_out and w_out/w_valid_out/w_tag_out are 1-cycle registers.
  - Data registers update only when the matching valid is 1. Valid registers update every cycle.
- Weight load: when w_valid_in && w_tag_in==PE_ID, buf[i_wb] <= w_in and loaded[i_wb] <= 1. The word is forwarded regardless of tag.
- Compute issue (stage 1):
  - Triggered when act_valid_in=1. Uses buffer c = !i_wb, sampled that cycle.
  - Row r, slot j: weight w, meta m. The selected operand is activation block j, element m. The product is signed 2*MUL_DW, sign-extended to ADD_DW.
  - Products, acc_in and the valid are registered.
  - If loaded[c]=0: products are forced to 0 and err <= 1.
- Stage 2:
  - Per row: sum of BETA products plus acc_in, registered to acc_out.
  - acc_valid_out = stage-1 valid delayed.
  - Latency from act_valid_in to acc_valid_out is 2 cycles.
  - Full throughput: one issue per cycle, no stall.
- Arithmetic:
  - SAT=0: result truncated mod 2^ADD_DW.
  - SAT=1: result clamped to [-2^(ADD_DW-1), 2^(ADD_DW-1)-1], computed with one guard bit.
- Dense mode is expressed with M=1 (META_W forced to 1, meta ignored) or by metadata 0..M-1. No separate mode input.
- Simultaneous events:
  - Load into buf[i_wb] and compute from buf[!i_wb] in the same cycle are independent.
  - Toggling i_wb takes effect for issues in the same cycle.
  - In-flight stage-1/stage-2 data is unaffected because products are captured at issue.
- acc_out holds its last value when acc_valid_out=0.
- Reset asserted mid-pipeline drops in-flight results; no acc_valid_out follows.

Test Plan:
- Defaults; load buffer 0 (i_wb=0, tag 0), row0 weights {3,-2,1,5} with meta {0,1,2,3}. Set i_wb=1, act block b element k = 10*b+k, acc_in=100 -> 2 cycles later acc_valid_out=1, row0 = 100 + 3·0 + (-2)·11 + 1·22 + 5·33 = 265.
- Word with w_tag_in=3 at PE_ID=0 -> not captured, loaded flags unchanged. w_out carries it 1 cycle later with w_valid_out=1.
- Compute with i_wb=0 immediately after reset, both buffers empty -> acc_out row = acc_in, err=1 and stays 1 until reset.
- Back-to-back: 4 consecutive act_valid_in with i_wb flipped after cycle 2, buffer 1 preloaded -> results 1-2 use buffer 0 and 3-4 use buffer 1, arriving on 4 consecutive cycles.
- SAT=1, ADD_DW=16, acc_in=32760, product 127·127 -> acc_out = 32767. With SAT=0 -> (32760+16129) mod 2^16 = 48889, read signed -16647.
- rst_n pulsed low 1 cycle after an issue -> acc_valid_out never asserts for it, all outputs 0 during reset.

Source files
------------

// File: rtl/sparse_pe_v2.sv
// sparse_pe_v2: weight-stationary sparse PE. Double-buffered N:M weights
// loaded over a tagged shift chain, metadata-driven activation select,
// two-stage multiply / reduce-accumulate pipeline, act/w/psum forwarding.
module sparse_pe_v2 #(
  parameter int ROWS   = 2,
  parameter int BETA   = 4,
  parameter int M      = 4,
  parameter int MUL_DW = 8,
  parameter int ADD_DW = 32,
  parameter int TAG_W  = 4,
  parameter int PE_ID  = 0,
  parameter int SAT    = 0
) (
  input  logic                                                   clk,
  input  logic                                                   rst_n,
  input  logic [MUL_DW*M*BETA-1:0]                               act_in,
  input  logic                                                   act_valid_in,
  input  logic [ROWS*ADD_DW-1:0]                                 acc_in,
  input  logic [ROWS*BETA*(MUL_DW+((M > 1) ? $clog2(M) : 1))-1:0] w_in,
  input  logic                                                   w_valid_in,
  input  logic [TAG_W-1:0]                                       w_tag_in,
  input  logic                                                   i_wb,
  input  logic                                                   clear,
  output logic [MUL_DW*M*BETA-1:0]                               act_out,
  output logic                                                   act_valid_out,
  output logic [ROWS*BETA*(MUL_DW+((M > 1) ? $clog2(M) : 1))-1:0] w_out,
  output logic                                                   w_valid_out,
  output logic [TAG_W-1:0]                                       w_tag_out,
  output logic [ROWS*ADD_DW-1:0]                                 acc_out,
  output logic                                                   acc_valid_out,
  output logic                                                   err
);

  localparam int META_W = (M > 1) ? $clog2(M) : 1;
  localparam int SW     = MUL_DW + META_W;
  localparam int WW     = ROWS * BETA * SW;
  localparam int PW     = 2 * MUL_DW;
  localparam int GW     = ADD_DW + 1;

  logic [WW-1:0]               wbuf0, wbuf1;
  logic [1:0]                  loaded;
  logic                        w_load;
  logic [WW-1:0]               cur_w;
  logic [SW-1:0]               slot;
  logic [META_W-1:0]           meta;
  logic signed [MUL_DW-1:0]    wgt, act;
  logic signed [PW-1:0]        prod;
  logic [ROWS*BETA*ADD_DW-1:0] prod_c, prod_q;
  logic [ROWS*ADD_DW-1:0]      acc1_q;
  logic                        v1_q;
  logic [ROWS*ADD_DW-1:0]      sum_c;
  logic signed [GW-1:0]        gsum;

  // A load coinciding with clear is dropped so the flushed loaded flags
  // never point at a half-committed buffer.
  assign w_load = !clear && w_valid_in && (w_tag_in == TAG_W'(PE_ID));

  // Shift-chain and activation forwarding; data only moves with its valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_out       <= '0;
      act_valid_out <= 1'b0;
      w_out         <= '0;
      w_valid_out   <= 1'b0;
      w_tag_out     <= '0;
    end else begin
      act_valid_out <= act_valid_in;
      w_valid_out   <= w_valid_in;
      if (act_valid_in) act_out <= act_in;
      if (w_valid_in) begin
        w_out     <= w_in;
        w_tag_out <= w_tag_in;
      end
    end
  end

  // Weight double buffer: tagged words land in buf[i_wb].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf0 <= '0;
      wbuf1 <= '0;
    end else if (w_load) begin
      if (i_wb) wbuf1 <= w_in;
      else      wbuf0 <= w_in;
    end
  end

  // Stage-1 operands: metadata picks each weight's activation from its block.
  always_comb begin
    cur_w  = i_wb ? wbuf0 : wbuf1;
    prod_c = '0;
    slot   = '0;
    meta   = '0;
    wgt    = '0;
    act    = '0;
    prod   = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      for (int unsigned j = 0; j < BETA; j++) begin
        slot = cur_w[(r*BETA+j)*SW +: SW];
        wgt  = slot[MUL_DW-1:0];
        meta = slot[SW-1:MUL_DW];
        act  = '0;
        for (int unsigned k = 0; k < M; k++) begin
          if (M == 1 || meta == META_W'(k)) act = act_in[(j*M+k)*MUL_DW +: MUL_DW];
        end
        prod = wgt * act;
        if (loaded[~i_wb]) prod_c[(r*BETA+j)*ADD_DW +: ADD_DW] = ADD_DW'(prod);
      end
    end
  end

  // Stage-2 reduction with one guard bit, then wrap or clamp.
  always_comb begin
    sum_c = '0;
    gsum  = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      gsum = GW'($signed(acc1_q[r*ADD_DW +: ADD_DW]));
      for (int unsigned j = 0; j < BETA; j++) begin
        gsum = gsum + GW'($signed(prod_q[(r*BETA+j)*ADD_DW +: ADD_DW]));
      end
      if (SAT != 0 && gsum[ADD_DW] != gsum[ADD_DW-1])
        sum_c[r*ADD_DW +: ADD_DW] = gsum[ADD_DW] ? {1'b1, {(ADD_DW-1){1'b0}}}
                                                 : {1'b0, {(ADD_DW-1){1'b1}}};
      else
        sum_c[r*ADD_DW +: ADD_DW] = gsum[ADD_DW-1:0];
    end
  end

  // Loaded flags, sticky error and the two pipeline stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loaded        <= '0;
      err           <= 1'b0;
      v1_q          <= 1'b0;
      prod_q        <= '0;
      acc1_q        <= '0;
      acc_valid_out <= 1'b0;
      acc_out       <= '0;
    end else if (clear) begin
      loaded        <= '0;
      err           <= 1'b0;
      v1_q          <= 1'b0;
      prod_q        <= '0;
      acc1_q        <= '0;
      acc_valid_out <= 1'b0;
      acc_out       <= '0;
    end else begin
      if (w_load) loaded[i_wb] <= 1'b1;
      v1_q <= act_valid_in;
      if (act_valid_in) begin
        prod_q <= prod_c;
        acc1_q <= acc_in;
        if (!loaded[~i_wb]) err <= 1'b1;
      end
      acc_valid_out <= v1_q;
      if (v1_q) acc_out <= sum_c;
    end
  end

endmodule

// File: tb/tb_sparse_pe_v2.sv
// Bench for sparse_pe_v2: directed scenarios plus randomized traffic, checked
// every cycle against a transaction-level model (dot products per issue).
module tb_sparse_pe_v2;
  localparam int ROWS = 2, BETA = 4, M = 4, MUL_DW = 8, ADD_DW = 32, TAG_W = 4;
  localparam int SW = 10, WW = ROWS*BETA*SW, AW = MUL_DW*M*BETA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, act_valid_in, w_valid_in, i_wb, clear;
  logic [AW-1:0] act_in;
  logic [ROWS*ADD_DW-1:0] acc_in;
  logic [ROWS*16-1:0] acc_in16;
  logic [WW-1:0] w_in;
  logic [TAG_W-1:0] w_tag_in;

  logic [AW-1:0] act_out, s_act_out, n_act_out;
  logic act_valid_out, s_act_valid_out, n_act_valid_out;
  logic [WW-1:0] w_out, s_w_out, n_w_out;
  logic w_valid_out, s_w_valid_out, n_w_valid_out;
  logic [TAG_W-1:0] w_tag_out, s_w_tag_out, n_w_tag_out;
  logic [ROWS*ADD_DW-1:0] acc_out;
  logic [ROWS*16-1:0] s_acc_out, n_acc_out;
  logic acc_valid_out, s_acc_valid_out, n_acc_valid_out;
  logic err, s_err, n_err;

  sparse_pe_v2 dut (
    .clk(clk), .rst_n(rst_n), .act_in(act_in), .act_valid_in(act_valid_in),
    .acc_in(acc_in), .w_in(w_in), .w_valid_in(w_valid_in), .w_tag_in(w_tag_in),
    .i_wb(i_wb), .clear(clear), .act_out(act_out), .act_valid_out(act_valid_out),
    .w_out(w_out), .w_valid_out(w_valid_out), .w_tag_out(w_tag_out),
    .acc_out(acc_out), .acc_valid_out(acc_valid_out), .err(err));

  sparse_pe_v2 #(.ADD_DW(16), .SAT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .act_in(act_in), .act_valid_in(act_valid_in),
    .acc_in(acc_in16), .w_in(w_in), .w_valid_in(w_valid_in), .w_tag_in(w_tag_in),
    .i_wb(i_wb), .clear(clear), .act_out(s_act_out), .act_valid_out(s_act_valid_out),
    .w_out(s_w_out), .w_valid_out(s_w_valid_out), .w_tag_out(s_w_tag_out),
    .acc_out(s_acc_out), .acc_valid_out(s_acc_valid_out), .err(s_err));

  sparse_pe_v2 #(.ADD_DW(16), .SAT(0)) dut_n (
    .clk(clk), .rst_n(rst_n), .act_in(act_in), .act_valid_in(act_valid_in),
    .acc_in(acc_in16), .w_in(w_in), .w_valid_in(w_valid_in), .w_tag_in(w_tag_in),
    .i_wb(i_wb), .clear(clear), .act_out(n_act_out), .act_valid_out(n_act_valid_out),
    .w_out(n_w_out), .w_valid_out(n_w_valid_out), .w_tag_out(n_w_tag_out),
    .acc_out(n_acc_out), .acc_valid_out(n_acc_valid_out), .err(n_err));

  int cmp_n = 0, fail_n = 0;

  // Reference model state
  int mw[2][ROWS][BETA];
  int mm[2][ROWS][BETA];
  bit mload[2];
  bit merr;
  logic [AW-1:0] e_act_out;
  logic [WW-1:0] e_w_out;
  logic [TAG_W-1:0] e_w_tag;
  logic [ROWS*ADD_DW-1:0] e_acc_out;
  bit e_act_v, e_w_v, e_acc_v, e_err;
  logic [ROWS*ADD_DW-1:0] res_q[$];
  int due_q[$];
  int cyc = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    cmp_n++;
    if (got !== exp) begin
      fail_n++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Dot product of the selected buffer against the current activations.
  function automatic logic [ROWS*ADD_DW-1:0] dot(input int c);
    logic [ROWS*ADD_DW-1:0] r = '0;
    for (int ro = 0; ro < ROWS; ro++) begin
      longint s;
      s = longint'($signed(acc_in[ro*32 +: 32]));
      if (mload[c])
        for (int j = 0; j < BETA; j++)
          s += longint'(mw[c][ro][j]) * longint'($signed(act_in[(j*M+mm[c][ro][j])*8 +: 8]));
      r[ro*32 +: 32] = s[31:0];
    end
    return r;
  endfunction

  // Advance the model across the coming clock edge using the driven inputs.
  task automatic model_edge();
    if (!rst_n) begin
      e_act_out = '0; e_act_v = 0; e_w_out = '0; e_w_v = 0; e_w_tag = '0;
      e_acc_out = '0; e_acc_v = 0; merr = 0; mload[0] = 0; mload[1] = 0;
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < ROWS; r++)
          for (int j = 0; j < BETA; j++) begin mw[b][r][j] = 0; mm[b][r][j] = 0; end
      res_q.delete(); due_q.delete();
    end else begin
      e_act_v = act_valid_in;
      if (act_valid_in) e_act_out = act_in;
      e_w_v = w_valid_in;
      if (w_valid_in) begin e_w_out = w_in; e_w_tag = w_tag_in; end
      if (clear) begin
        mload[0] = 0; mload[1] = 0; merr = 0; e_acc_v = 0; e_acc_out = '0;
        res_q.delete(); due_q.delete();
      end else begin
        e_acc_v = 0;
        if (due_q.size() > 0 && due_q[0] == cyc) begin
          e_acc_v = 1;
          e_acc_out = res_q.pop_front();
          void'(due_q.pop_front());
        end
        if (act_valid_in) begin
          int c = i_wb ? 0 : 1;
          if (!mload[c]) merr = 1;
          res_q.push_back(dot(c));
          due_q.push_back(cyc + 1);
        end
        if (w_valid_in && w_tag_in == 0) begin
          for (int r = 0; r < ROWS; r++)
            for (int j = 0; j < BETA; j++) begin
              mw[i_wb][r][j] = $signed(w_in[(r*BETA+j)*SW +: 8]);
              mm[i_wb][r][j] = int'(w_in[(r*BETA+j)*SW+8 +: 2]);
            end
          mload[i_wb] = 1;
        end
      end
    end
    e_err = merr;
  endtask

  // Compare process: every cycle, just after the edge.
  always @(posedge clk) begin
    #1;
    chk("act_valid_out", act_valid_out, e_act_v);
    chk("act_out", act_out, e_act_out);
    chk("w_valid_out", w_valid_out, e_w_v);
    chk("w_out", w_out, e_w_out);
    chk("w_tag_out", w_tag_out, e_w_tag);
    chk("acc_valid_out", acc_valid_out, e_acc_v);
    chk("acc_out", acc_out, e_acc_out);
    chk("err", err, e_err);
  end

  task automatic tick();
    model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle();
    act_valid_in = 0; w_valid_in = 0; clear = 0;
  endtask

  task automatic set_slot(input int r, input int j, input int w, input int m);
    w_in[(r*BETA+j)*SW +: SW] = {2'(m), 8'(w)};
  endtask

  logic [WW-1:0] saved_w;

  initial begin
    rst_n = 0; act_in = '0; act_valid_in = 0; acc_in = '0; acc_in16 = '0;
    w_in = '0; w_valid_in = 0; w_tag_in = '0; i_wb = 0; clear = 0;
    tick(); tick();
    rst_n = 1;
    tick();

    // Compute from an empty buffer straight after reset
    i_wb = 0; act_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    acc_in = {32'd7, 32'hFFFF_FFFB}; act_valid_in = 1;
    tick(); idle(); tick();
    chk("empty_row0", acc_out[31:0], 32'hFFFF_FFFB);
    chk("empty_row1", acc_out[63:32], 32'd7);
    chk("empty_err", err, 1'b1);

    // Load buffer 0 and compute from it
    w_in = '0;
    set_slot(0, 0, 3, 0); set_slot(0, 1, -2, 1); set_slot(0, 2, 1, 2); set_slot(0, 3, 5, 3);
    for (int j = 0; j < BETA; j++) set_slot(1, j, 1, 0);
    i_wb = 0; w_tag_in = 0; w_valid_in = 1;
    tick(); idle();
    for (int b = 0; b < BETA; b++)
      for (int k = 0; k < M; k++) act_in[(b*M+k)*8 +: 8] = 8'(10*b + k);
    i_wb = 1; acc_in = {32'd100, 32'd100}; act_valid_in = 1;
    tick(); idle(); tick();
    chk("dense_valid", acc_valid_out, 1'b1);
    chk("dot_row0", acc_out[31:0], 32'd265);
    chk("dot_row1", acc_out[63:32], 32'd160);
    chk("err_sticky", err, 1'b1);

    // Foreign tag: forwarded, not captured
    saved_w = {$urandom(), $urandom(), $urandom()};
    w_in = saved_w; w_tag_in = 3; w_valid_in = 1;
    tick(); idle();
    chk("fwd_w_valid", w_valid_out, 1'b1);
    chk("fwd_w_tag", w_tag_out, 4'd3);
    chk("fwd_w_data", w_out, saved_w);

    // Back-to-back issues across a buffer swap
    w_in = {$urandom(), $urandom(), $urandom()}; w_tag_in = 0; i_wb = 1; w_valid_in = 1;
    tick();
    w_in = {$urandom(), $urandom(), $urandom()}; i_wb = 0;
    tick(); idle();
    for (int t = 0; t < 4; t++) begin
      i_wb = (t < 2);
      act_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      acc_in = {$urandom(), $urandom()};
      act_valid_in = 1;
      tick();
    end
    idle(); tick(); tick();

    // Saturation vs wrap at ADD_DW=16
    w_in = '0; set_slot(0, 0, 127, 0);
    i_wb = 0; w_tag_in = 0; w_valid_in = 1;
    tick(); idle();
    act_in = {$urandom(), $urandom(), $urandom(), $urandom()};
    act_in[7:0] = 8'd127;
    acc_in16 = {16'd0, 16'd32760}; i_wb = 1; act_valid_in = 1;
    tick(); idle(); tick();
    chk("sat_valid", s_acc_valid_out, 1'b1);
    chk("sat_clamp", s_acc_out[15:0], 16'd32767);
    chk("wrap_mod", n_acc_out[15:0], 16'd48889);

    // Reset one cycle after an issue drops the result
    act_in = {$urandom(), $urandom(), $urandom(), $urandom()}; act_valid_in = 1;
    tick(); idle();
    rst_n = 0;
    #1;
    chk("rst_acc_valid", acc_valid_out, 1'b0);
    chk("rst_act_valid", act_valid_out, 1'b0);
    chk("rst_acc_out", acc_out, '0);
    chk("rst_err", err, 1'b0);
    tick();
    rst_n = 1;
    tick(); tick(); tick();

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      act_valid_in = ($urandom_range(0, 9) < 7);
      act_in = {$urandom(), $urandom(), $urandom(), $urandom()};
      acc_in = {$urandom(), $urandom()};
      acc_in16 = $urandom();
      w_valid_in = ($urandom_range(0, 9) < 3);
      w_in = WW'({$urandom(), $urandom(), $urandom()});
      w_tag_in = TAG_W'($urandom_range(0, 2));
      if ($urandom_range(0, 4) == 0) i_wb = ~i_wb;
      clear = !w_valid_in && ($urandom_range(0, 39) == 0);
      tick();
    end
    idle();
    tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, fail_n);
    $finish;
  end
endmodule
